ppm_rx_frame_ctrl: RTL and testbench
====================================

Name: ppm_rx_frame_ctrl

Overview:
Receive-side frame controller placed directly after the 4-PPM symbol decoder. It consumes the decoder's SOF strobe (F_en), byte strobe (D_en) and byte (Dout), and parses each frame as a length byte, then payload bytes, then an XOR checksum. Only frames that pass every check are written into a circular byte buffer; failed frames are rolled back. Committed payload is streamed to the downstream MAC over a valid/ready interface with a last-byte marker.

Parameters:
MAX_LEN, 64, maximum legal payload length in bytes (1..255).
DEPTH, 128, buffer depth in entries; power of 2, must be >= MAX_LEN.
TIMEOUT, 2048, idle cycles without a decoder strobe before an in-progress frame is aborted (one decoded byte = 512 clk).

Ports:
clk  in  1  system clock, same domain as the decoder.
rst  in  1  asynchronous, active-low reset.
dec_data  in  8  decoded byte; valid only when dec_den=1.
dec_den  in  1  one-cycle byte strobe from the decoder.
dec_fen  in  1  one-cycle start-of-frame strobe from the decoder.
m_data  out  8  payload byte to downstream.
m_valid  out  1  m_data is valid.
m_last  out  1  m_data is the final payload byte of its frame.
m_ready  in  1  downstream accepts the byte.
frame_ok  out  1  one-cycle pulse when a frame is committed.
frame_err  out  1  one-cycle pulse when a frame is dropped.
err_code  out  2  held from the last drop: 0 overflow, 1 bad length, 2 timeout/abort, 3 checksum.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, all pointers 0, state IDLE, buffer contents don't-care.
- Buffer entry format: 9 bits, {last, data}. Pointers are log2(DEPTH)+1 bits wide so that full and empty can be told apart.
- Pointers:
  - wr_spec is the speculative write pointer.
  - wr_com is the committed write pointer.
  - rd_ptr is the read pointer.
  - full when wr_spec - rd_ptr == DEPTH (modulo pointer width).
- States:
  - IDLE: dec_den is ignored. dec_fen -> LEN; clear running checksum csum and byte counter cnt.
  - LEN: on dec_den, store len=dec_data and set csum=dec_data.
    - len==0 or len>MAX_LEN -> drop with code 1.
    - otherwise -> PAYLOAD.
  - PAYLOAD: on dec_den:
    - if full -> drop with code 0;
    - else write {cnt==len-1, dec_data} at wr_spec, wr_spec++, csum ^= dec_data, cnt++;
    - when cnt reaches len -> CHECK.
  - CHECK: on dec_den, compare dec_data with csum.
    - equal -> commit (wr_com <= wr_spec, frame_ok=1) -> IDLE.
    - not equal -> drop with code 3.
- Drop: wr_spec <= wr_com, frame_err=1, err_code updated, -> IDLE. frame_ok and frame_err are registered and assert the cycle after the triggering strobe.
- dec_fen in LEN, PAYLOAD or CHECK: drop the current frame with code 2, then immediately restart in LEN (csum and cnt cleared); do not pass through IDLE.
- dec_fen and dec_den in the same cycle: dec_fen has priority and dec_den is ignored.
- Timeout: a counter clears on every dec_den or dec_fen and increments each cycle in LEN, PAYLOAD and CHECK. When it reaches TIMEOUT-1 -> drop with code 2.
- Read side:
  - m_valid = (rd_ptr != wr_com).
  - {m_last, m_data} = mem[rd_ptr], first-word-fall-through (combinational read).
  - m_valid && m_ready -> rd_ptr++.
  - m_valid must not depend combinationally on m_ready.
- Latency: the first committed byte presents m_valid one cycle after frame_ok.
- Concurrency: read and write in the same cycle are legal. Commit and read in the same cycle are legal. Rollback never moves wr_spec behind rd_ptr, because it only returns to wr_com.
- Pointer wrap-around is modulo 2*DEPTH; a frame may straddle the buffer end.
- Reset mid-frame or mid-read discards everything asynchronously; no strobe is produced.

Test Plan:
1. Good frame: fen, then bytes 03 A5 3C 0F 95 at a 512-cycle spacing, m_ready=1 -> frame_ok pulses once; stream A5, 3C, 0F with m_last only on 0F; frame_err stays 0.
2. Bad checksum: same frame with the final byte 94 -> frame_err pulses, err_code=3, m_valid never asserts, wr_spec returns to its prior value.
3. Bad length: fen, then byte 00; repeat with byte 41 (65 > MAX_LEN) -> frame_err each time with err_code=1, back to IDLE; following dec_den strobes are ignored.
4. Timeout and abort:
   - fen, 03, A5, then silence for 2048 cycles -> frame_err with err_code=2, busy=0.
   - separately, a second fen mid-payload -> err_code=2, then a new good frame is accepted.
5. Overflow and backpressure (DEPTH=8): hold m_ready=0, commit a 5-byte frame, then send a 5-byte frame -> drop with err_code=0 on the 4th payload byte. Release m_ready -> exactly the first 5 bytes are read, with m_last on the 5th.
6. Wrap-around and concurrency (DEPTH=8): 3-byte frames back-to-back with random m_ready over 10 frames -> all payloads arrive in order across pointer wrap.
7. Async reset mid-payload -> all outputs are 0 immediately.

Source files
------------

// File: rtl/ppm_rx_frame_ctrl_if.sv
// Purpose: payload stream from the PPM receive frame controller to the MAC.
// Latency: n/a (signal bundle only).
// Backpressure: m_ready from the MAC stalls the stream; m_valid never depends on m_ready.
// Signals:
//   m_data  - payload byte
//   m_valid - m_data/m_last are valid
//   m_last  - final payload byte of its frame
//   m_ready - downstream accepts the byte
interface ppm_rx_frame_ctrl_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/ppm_rx_frame_ctrl.sv
// Purpose: parse decoded 4-PPM frames (len, payload, xor checksum) into a circular buffer, commit or roll back.
// Latency: frame_ok/frame_err one cycle after the deciding strobe; first byte valid one cycle after frame_ok.
// Backpressure: m_ready stalls reads; a frame that would overfill the buffer is dropped (err_code 0).
// Ports:
//   clk, rst                     - clock, asynchronous active-low reset
//   dec_data/dec_den/dec_fen     - decoded byte, byte strobe, start-of-frame strobe
//   m (master)                   - payload stream {m_data, m_valid, m_last, m_ready}
//   frame_ok/frame_err           - one-cycle commit / drop pulses
//   err_code                     - reason of the last drop: 0 overflow, 1 bad length, 2 timeout/abort, 3 checksum
//   busy                         - frame parsing in progress
module ppm_rx_frame_ctrl #(
    parameter int MAX_LEN = 64,
    parameter int DEPTH   = 128,
    parameter int TIMEOUT = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            dec_data,
    input  logic                  dec_den,
    input  logic                  dec_fen,
    ppm_rx_frame_ctrl_if.master   m,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic                  busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    len;
    logic [7:0]    csum;
    logic [7:0]    cnt;
    logic [TW-1:0] tmo_cnt;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PW-1:0] wr_spec;
    logic [PW-1:0] wr_com;
    logic [PW-1:0] wr_pub;
    logic [PW-1:0] rd_ptr;

    logic [8:0]    mem [DEPTH];
    logic [8:0]    rd_word;

    logic          full;
    logic          len_bad;
    logic          drop;
    logic [1:0]    drop_code;
    logic          commit;
    logic          wr_en;

    assign full    = ((wr_spec - rd_ptr) == PTR_FULL);
    assign len_bad = (dec_data == 8'd0) || (dec_data > 8'(MAX_LEN));
    assign busy    = (state != ST_IDLE);

    // Decide this cycle's outcome. dec_fen outranks dec_den, which outranks the timeout.
    always_comb begin
        drop      = 1'b0;
        drop_code = 2'd0;
        commit    = 1'b0;
        wr_en     = 1'b0;
        if (dec_fen) begin
            if (state != ST_IDLE) begin
                drop      = 1'b1;
                drop_code = 2'd2;
            end
        end else if (dec_den) begin
            unique case (state)
                ST_LEN: begin
                    if (len_bad) begin
                        drop      = 1'b1;
                        drop_code = 2'd1;
                    end
                end
                ST_PAYLOAD: begin
                    if (full) begin
                        drop      = 1'b1;
                        drop_code = 2'd0;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (dec_data == csum) begin
                        commit = 1'b1;
                    end else begin
                        drop      = 1'b1;
                        drop_code = 2'd3;
                    end
                end
                default: ;
            endcase
        end else if ((state != ST_IDLE) && (tmo_cnt == TMO_LAST)) begin
            drop      = 1'b1;
            drop_code = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            len       <= '0;
            csum      <= '0;
            cnt       <= '0;
            tmo_cnt   <= '0;
            wr_spec   <= '0;
            wr_com    <= '0;
            wr_pub    <= '0;
            rd_ptr    <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            frame_ok  <= commit;
            frame_err <= drop;
            if (drop) begin
                err_code <= drop_code;
            end

            // The reader only sees a commit one cycle later, so m_valid trails frame_ok.
            wr_pub <= wr_com;

            if (m.m_valid && m.m_ready) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (dec_den || dec_fen || (state == ST_IDLE)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (commit) begin
                wr_com <= wr_spec;
            end

            // Rollback returns to wr_com, which is never behind rd_ptr.
            if (drop) begin
                wr_spec <= wr_com;
            end else if (wr_en) begin
                wr_spec <= wr_spec + 1'b1;
            end

            if (dec_fen) begin
                state <= ST_LEN;
                csum  <= '0;
                cnt   <= '0;
            end else if (drop || commit) begin
                state <= ST_IDLE;
            end else if (dec_den) begin
                unique case (state)
                    ST_LEN: begin
                        len   <= dec_data;
                        csum  <= dec_data;
                        state <= ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        csum <= csum ^ dec_data;
                        cnt  <= cnt + 8'd1;
                        if ((cnt + 8'd1) == len) begin
                            state <= ST_CHECK;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Buffer storage carries no reset; only pointer-covered entries are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_spec[AW-1:0]] <= {(cnt == (len - 8'd1)), dec_data};
        end
    end

    assign rd_word   = mem[rd_ptr[AW-1:0]];
    assign m.m_valid = (rd_ptr != wr_pub);
    // Masked so the stream reads as zero whenever nothing is presented, including in reset.
    assign m.m_data  = m.m_valid ? rd_word[7:0] : 8'd0;
    assign m.m_last  = m.m_valid ? rd_word[8]   : 1'b0;
endmodule

// File: tb/tb_ppm_rx_frame_ctrl.sv
module tb_ppm_rx_frame_ctrl;
    localparam int MAXL = 8;
    localparam int DEP  = 8;
    localparam int TMO  = 2048;

    logic       clk;
    logic       rst;
    logic [7:0] dec_data;
    logic       dec_den;
    logic       dec_fen;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    ppm_rx_frame_ctrl_if mif ();

    ppm_rx_frame_ctrl #(.MAX_LEN(MAXL), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_data  (dec_data),
        .dec_den   (dec_den),
        .dec_fen   (dec_fen),
        .m         (mif),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ok_cnt   = 0;
    int err_cnt  = 0;
    int exp_ok   = 0;
    int exp_err  = 0;
    int exp_code = 0;
    int exp_wr   = 0;
    int rdy_mode = 0;

    logic [7:0] tx_q  [$];
    logic [8:0] rx_q  [$];
    logic [8:0] exp_q [$];

    // Output monitor: collects accepted stream words and counts status pulses.
    always @(negedge clk) begin
        if (rst) begin
            if (mif.m_valid && mif.m_ready) rx_q.push_back({mif.m_last, mif.m_data});
            if (frame_ok)  ok_cnt++;
            if (frame_err) err_cnt++;
        end
    end

    // Downstream ready driver: 0 = stalled, 1 = always ready, 2 = random.
    initial begin
        mif.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       mif.m_ready = 1'b0;
                1:       mif.m_ready = 1'b1;
                default: mif.m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic pulse_fen(input int gap);
        dec_fen = 1'b1;
        @(posedge clk); #1;
        dec_fen = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gap);
        dec_den  = 1'b1;
        dec_data = b;
        @(posedge clk); #1;
        dec_den  = 1'b0;
        dec_data = $urandom_range(0, 255);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int gap);
        pulse_fen(gap);
        foreach (tx_q[i]) drive_byte(tx_q[i], gap);
    endtask

    task automatic settle();
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Reference outcome of the frame in tx_q, assuming room in the buffer:
    // -1 accepted, otherwise the drop code.
    function automatic int ref_frame();
        logic [7:0] x;
        int l;
        if (tx_q.size() < 1) return 2;
        l = tx_q[0];
        if (l == 0 || l > MAXL) return 1;
        if (tx_q.size() < l + 2) return 2;
        x = 8'd0;
        for (int i = 0; i < l + 2; i++) x ^= tx_q[i];
        return (x == 8'd0) ? -1 : 3;
    endfunction

    task automatic model_frame();
        int r;
        int l;
        r = ref_frame();
        if (r < 0) begin
            l = tx_q[0];
            for (int i = 1; i <= l; i++) exp_q.push_back({(i == l), tx_q[i]});
            exp_ok++;
            exp_wr += l;
        end else begin
            exp_err++;
            exp_code = r;
        end
    endtask

    task automatic make_frame(input int l, input bit corrupt);
        logic [7:0] x;
        tx_q.delete();
        tx_q.push_back(8'(l));
        x = 8'(l);
        for (int i = 0; i < l; i++) begin
            tx_q.push_back(8'($urandom_range(0, 255)));
            x ^= tx_q[i + 1];
        end
        tx_q.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
    endtask

    task automatic check_stream(input string tag);
        int n;
        for (int i = 0; i < 3000 && rx_q.size() < exp_q.size(); i++) begin
            @(posedge clk); #1;
        end
        repeat (4) begin @(posedge clk); #1; end
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_word"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_ok_cnt"},  ok_cnt,  exp_ok);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        check({tag, "_wr_spec"}, 32'(dut.wr_spec), exp_wr % (2 * DEP));
    endtask

    initial begin
        int e0;
        int waited;
        rst      = 1'b0;
        dec_data = 8'd0;
        dec_den  = 1'b0;
        dec_fen  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid",   mif.m_valid, 0);
        check("rst_m_data",    mif.m_data,  0);
        check("rst_m_last",    mif.m_last,  0);
        check("rst_frame_ok",  frame_ok,    0);
        check("rst_frame_err", frame_err,   0);
        check("rst_err_code",  err_code,    0);
        check("rst_busy",      busy,        0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: good frame at decoder pace, latency of frame_ok and first byte
        rdy_mode = 1;
        tx_q = '{8'h03, 8'hA5, 8'h3C, 8'h0F, 8'h95};
        pulse_fen(511);
        check("t1_busy", busy, 1);
        for (int i = 0; i < 4; i++) drive_byte(tx_q[i], 511);
        drive_byte(tx_q[4], 0);
        check("t1_frame_ok_pulse", frame_ok, 1);
        check("t1_m_valid_lag",    mif.m_valid, 0);
        @(posedge clk); #1;
        check("t1_frame_ok_once",  frame_ok, 0);
        check("t1_m_valid_first",  mif.m_valid, 1);
        check("t1_m_data_first",   mif.m_data, 8'hA5);
        model_frame();
        check_stream("t1");
        check_counts("t1");

        // 2: bad checksum
        tx_q = '{8'h03, 8'hA5, 8'h3C, 8'h0F, 8'h94};
        send_frame(3);
        settle();
        model_frame();
        check("t2_err_code", err_code, exp_code);
        check("t2_busy", busy, 0);
        check_stream("t2");
        check_counts("t2");

        // 3: bad lengths (zero, far too long, one past the limit); later strobes ignored
        for (int k = 0; k < 3; k++) begin
            tx_q.delete();
            tx_q.push_back((k == 0) ? 8'h00 : (k == 1) ? 8'h41 : 8'(MAXL + 1));
            pulse_fen(2);
            drive_byte(tx_q[0], 2);
            settle();
            model_frame();
            check("t3_err_code", err_code, exp_code);
            check("t3_busy", busy, 0);
            for (int i = 0; i < 3; i++) drive_byte(8'($urandom_range(0, 255)), 2);
            check("t3_idle_busy", busy, 0);
            check_counts("t3");
        end
        // Longest legal frame
        make_frame(MAXL, 1'b0);
        send_frame(2);
        model_frame();
        check_stream("t3_maxlen");
        check_counts("t3_maxlen");

        // 4a: timeout after silence
        tx_q = '{8'h03, 8'hA5};
        pulse_fen(2);
        drive_byte(tx_q[0], 2);
        drive_byte(tx_q[1], 0);
        e0 = err_cnt;
        repeat (TMO - 20) begin @(posedge clk); #1; end
        check("t4_no_early_timeout", err_cnt, e0);
        waited = 0;
        while (err_cnt == e0 && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        exp_err++;
        check("t4_timeout_err", err_cnt, e0 + 1);
        check("t4_err_code", err_code, 2);
        check("t4_busy", busy, 0);
        check_counts("t4a");

        // 4b: second start-of-frame mid-payload aborts, restart accepted
        pulse_fen(2);
        drive_byte(8'h03, 2);
        drive_byte(8'hA5, 2);
        pulse_fen(0);
        check("t4b_abort_pulse", frame_err, 1);
        check("t4b_err_code", err_code, 2);
        check("t4b_busy_restart", busy, 1);
        exp_err++;
        tx_q = '{8'h02, 8'h11, 8'h22, 8'h31};
        foreach (tx_q[i]) drive_byte(tx_q[i], 2);
        model_frame();
        check_stream("t4b");
        check_counts("t4b");

        // 5: overflow under backpressure
        rdy_mode = 0;
        settle();
        tx_q = '{8'h05, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h05 ^ 8'h10 ^ 8'h11 ^ 8'h12 ^ 8'h13 ^ 8'h14};
        send_frame(2);
        model_frame();
        tx_q = '{8'h05, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h05 ^ 8'h20 ^ 8'h21 ^ 8'h22 ^ 8'h23 ^ 8'h24};
        send_frame(2);
        exp_err++;   // 3 bytes fit behind the first frame, the 4th finds the buffer full
        settle();
        check("t5_err_code", err_code, 0);
        check("t5_busy", busy, 0);
        check("t5_m_valid_held", mif.m_valid, 1);
        check("t5_m_data_held", mif.m_data, 8'h10);
        check_counts("t5");
        rdy_mode = 1;
        check_stream("t5");
        check("t5_drained", mif.m_valid, 0);

        // 6: back-to-back short frames, random ready, pointer wrap
        rdy_mode = 2;
        for (int f = 0; f < 10; f++) begin
            make_frame(3, ($urandom_range(0, 3) == 0));
            send_frame($urandom_range(4, 10));
            model_frame();
        end
        rdy_mode = 1;
        check_stream("t6");
        check_counts("t6");

        // 7: asynchronous reset mid-payload with data pending
        rdy_mode = 0;
        settle();
        make_frame(2, 1'b0);
        send_frame(2);
        model_frame();
        make_frame(2, 1'b1);
        send_frame(2);
        model_frame();
        settle();
        check("t7_pre_m_valid", mif.m_valid, 1);
        check("t7_pre_err_code", err_code, 3);
        pulse_fen(2);
        drive_byte(8'h04, 2);
        drive_byte(8'h5A, 0);
        #3;
        rst = 1'b0;
        #1;
        check("t7_m_valid",   mif.m_valid, 0);
        check("t7_m_data",    mif.m_data,  0);
        check("t7_m_last",    mif.m_last,  0);
        check("t7_frame_ok",  frame_ok,    0);
        check("t7_frame_err", frame_err,   0);
        check("t7_err_code",  err_code,    0);
        check("t7_busy",      busy,        0);
        @(negedge clk);
        rst = 1'b1;
        rx_q.delete();
        exp_q.delete();
        exp_wr = 0;
        @(posedge clk); #1;
        check_counts("t7_after_reset");
        rdy_mode = 1;
        make_frame(4, 1'b0);
        send_frame(2);
        model_frame();
        check_stream("t7_post");
        check_counts("t7_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
